// File: rtl/cfg_loader.sv
// Configuration loader for one X/Y routing tile.
// Takes a word-serial bitstream over valid/ready, assembles it in a shadow
// register and verifies an XOR checksum word. On a match it commits the
// whole image to the active registers that drive the X-matrix and Y-array
// programming buses in a single cycle.
module cfg_loader #(
    parameter int V = 4,
    parameter int H = 4,
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [W-1:0]    cfg_data,
    output logic [V*H-1:0]  x_prog,
    output logic [V-1:0]    y_prog,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CFG_BITS = V*H + V;
    localparam int NWORDS   = (CFG_BITS + W - 1) / W;
    localparam int CW       = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Only CFG_BITS are kept. The padding in the first word is shifted out
    // past the top during the load, so it never reaches the active image.
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [W-1:0]        acc;
    logic [CW-1:0]       cnt;

    logic                hs;
    logic                last_word;
    logic                csum_ok;

    assign hs        = cfg_valid && cfg_ready;
    assign last_word = (cnt == CW'(NWORDS - 1));
    assign csum_ok   = (cfg_data == acc);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: stalls hold the state; start is only seen in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)           state_nxt = LOAD;
            LOAD:    if (hs && last_word) state_nxt = CSUM;
            CSUM:    if (hs)              state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; cfg_ready depends on the state alone
    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD:    begin cfg_ready = 1'b1; busy = 1'b1; end
            CSUM:    begin cfg_ready = 1'b1; busy = 1'b1; end
            default: begin cfg_ready = 1'b0; busy = 1'b0; end
        endcase
    end

    // Datapath: shadow assembly, checksum, counter and atomic commit.
    // Reset also clears the active image so the fabric falls back to
    // pass-through X nodes and blocked Y nodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            acc    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        acc <= '0;
                        err <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        shadow <= CFG_BITS'({shadow, cfg_data});
                        acc    <= acc ^ cfg_data;
                        cnt    <= cnt + CW'(1);
                    end
                end
                CSUM: begin
                    if (hs) begin
                        if (csum_ok) begin
                            active <= shadow;
                            done   <= 1'b1;
                        end else begin
                            err    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_prog = active[CFG_BITS-1:V];
    assign y_prog = active[V-1:0];

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: a default-size instance (V=H=4, W=8)
// driven by directed and randomized sessions, plus a small V=2,H=2,W=4
// instance for the hand-worked basic and bad-checksum cases.
module tb_cfg_loader;

    localparam int V    = 4;
    localparam int H    = 4;
    localparam int W    = 8;
    localparam int CB   = V*H + V;
    localparam int NW   = (CB + W - 1) / W;
    localparam int PADW = NW*W - CB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;

    logic           start = 1'b0, cfg_valid = 1'b0, cfg_ready;
    logic [W-1:0]   cfg_data = '0;
    logic [V*H-1:0] x_prog;
    logic [V-1:0]   y_prog;
    logic           busy, done, err;

    logic           s_start = 1'b0, s_valid = 1'b0, s_ready;
    logic [3:0]     s_data = '0;
    logic [3:0]     s_x;
    logic [1:0]     s_y;
    logic           s_busy, s_done, s_err;

    int checks = 0;
    int errors = 0;

    // Reference view of what the fabric should currently be seeing
    logic [V*H-1:0] exp_x = '0;
    logic [V-1:0]   exp_y = '0;

    always #5 clk = ~clk;

    cfg_loader #(.V(V), .H(H), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data), .x_prog(x_prog),
        .y_prog(y_prog), .busy(busy), .done(done), .err(err)
    );

    cfg_loader #(.V(2), .H(2), .W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .cfg_valid(s_valid),
        .cfg_ready(s_ready), .cfg_data(s_data), .x_prog(s_x),
        .y_prog(s_y), .busy(s_busy), .done(s_done), .err(s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full session on the main instance. The word stream is built from
    // the image: {padding, cfg} split MSB-first into W-bit words, followed by
    // the XOR of those words (corrupted when bad=1). poke=1 pulses start
    // during the gap before the third word, which must be ignored.
    task automatic session(input logic [CB-1:0] cfg, input logic [PADW-1:0] pad,
                           input bit bad, input int gap, input bit poke);
        logic [NW*W-1:0] full;
        logic [W-1:0]    w [NW+1];
        logic [W-1:0]    cs;
        full = {pad, cfg};
        cs   = '0;
        for (int i = 0; i < NW; i++) begin
            w[i] = full[(NW-i)*W-1 -: W];
            cs   = cs ^ w[i];
        end
        w[NW] = bad ? (cs ^ 8'($urandom_range(1, 255))) : cs;

        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_clears_err got %b want 0", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end

        for (int i = 0; i <= NW; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = (poke && i == 2);
                tick();
                checks++;
                if (x_prog !== exp_x || y_prog !== exp_y || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold x=%h y=%h done=%b busy=%b want x=%h y=%h done=0 busy=1",
                             x_prog, y_prog, done, busy, exp_x, exp_y);
                end
            end
            start = 1'b0;
            cfg_valid = 1'b1;
            cfg_data  = w[i];
            checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_word%0d got %b want 1", i, cfg_ready); end
            tick();
            cfg_valid = 1'b0;
            if (i < NW) begin
                checks++;
                if (x_prog !== exp_x || y_prog !== exp_y || done !== 1'b0) begin
                    errors++;
                    $display("FAIL partial_hidden x=%h y=%h done=%b want x=%h y=%h done=0",
                             x_prog, y_prog, done, exp_x, exp_y);
                end
            end
        end

        if (!bad) begin
            exp_x = cfg[CB-1:V];
            exp_y = cfg[V-1:0];
        end
        checks++;
        if (x_prog !== exp_x || y_prog !== exp_y) begin
            errors++;
            $display("FAIL commit_value x=%h y=%h want x=%h y=%h", x_prog, y_prog, exp_x, exp_y);
        end
        checks++; if (done !== !bad) begin errors++; $display("FAIL commit_done got %b want %b", done, !bad); end
        checks++; if (err !== bad) begin errors++; $display("FAIL commit_err got %b want %b", err, bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL commit_busy got %b want 0", busy); end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (x_prog !== '0 || y_prog !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_main x=%h y=%h busy=%b done=%b err=%b rdy=%b want all 0",
                     x_prog, y_prog, busy, done, err, cfg_ready);
        end
        checks++;
        if (s_x !== '0 || s_y !== '0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_small x=%h y=%h busy=%b done=%b err=%b want all 0",
                     s_x, s_y, s_busy, s_done, s_err);
        end
        #4 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_valid = 1'b1;
        s_data = 4'h3; tick();
        s_data = 4'hA; tick();
        s_data = 4'h9; tick();
        s_valid = 1'b0;
        checks++; if (s_x !== 4'b1110) begin errors++; $display("FAIL basic_x got %b want 1110", s_x); end
        checks++; if (s_y !== 2'b10) begin errors++; $display("FAIL basic_y got %b want 10", s_y); end
        checks++; if (s_done !== 1'b1 || s_busy !== 1'b0 || s_err !== 1'b0) begin
            errors++; $display("FAIL basic_flags done=%b busy=%b err=%b want 1 0 0", s_done, s_busy, s_err); end
        tick();
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", s_done); end
    endtask

    task automatic test_bad_csum();
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_valid = 1'b1;
        s_data = 4'h3; tick();
        s_data = 4'hA; tick();
        s_data = 4'h8; tick();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s_err !== 1'b1 || s_done !== 1'b0 || s_x !== 4'b1110 || s_y !== 2'b10) begin
                errors++;
                $display("FAIL bad_csum err=%b done=%b x=%b y=%b want 1 0 1110 10", s_err, s_done, s_x, s_y);
            end
            tick();
        end
        s_start = 1'b1; tick(); s_start = 1'b0;
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL bad_csum_clear got %b want 0", s_err); end
        s_valid = 1'b1;
        s_data = 4'h0; tick();
        s_data = 4'h5; tick();
        s_data = 4'h5; tick();
        s_valid = 1'b0;
        checks++; if (s_x !== 4'b0001 || s_y !== 2'b01 || s_done !== 1'b1) begin
            errors++; $display("FAIL bad_csum_recover x=%b y=%b done=%b want 0001 01 1", s_x, s_y, s_done); end
    endtask

    task automatic test_gaps();
        session(20'h12345, 4'hF, 1'b0, 3, 1'b0);
        checks++; if (x_prog !== 16'h1234 || y_prog !== 4'h5) begin
            errors++; $display("FAIL gaps_value x=%h y=%h want 1234 5", x_prog, y_prog); end
    endtask

    task automatic test_misuse();
        tick();
        cfg_valid = 1'b1;
        cfg_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_valid rdy=%b busy=%b want 0 0", cfg_ready, busy);
            end
        end
        // cfg_valid stays high with 0xFF through the start cycle
        session(20'hA5C3E, 4'h0, 1'b0, 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        session(20'h6B2D9, 4'h7, 1'b0, 0, 1'b0);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'h3C; tick();
        cfg_data = 8'hC3; tick();
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_x = '0;
        exp_y = '0;
        checks++;
        if (x_prog !== '0 || y_prog !== '0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset x=%h y=%h busy=%b rdy=%b want 0 0 0 0", x_prog, y_prog, busy, cfg_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        session(20'h0F0F1, 4'h2, 1'b0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            session(20'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_gaps();
        test_misuse();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
